// File: rtl/card_dealer_if.sv
//------------------------------------------------------------------------------
// card_dealer_if
//   Bundles the card_dealer control, scorer-facing beat and statistics signals.
//   master : the dealer (drives beats/statistics, receives control/results)
//   slave  : the environment (drives control and scorer results)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface card_dealer_if;
  logic        start;       // begin one hand (IDLE only)
  logic        seed_load;   // load seed into LFSR (IDLE only, beats start)
  logic [15:0] seed;        // LFSR seed
  logic        win;         // scorer win flag
  logic        lose;        // scorer lose flag
  logic        out_valid;   // card/clear beat to scorer in_valid
  logic [3:0]  card;        // rank 1..13, 0 on clear beats and when quiet
  logic        busy;        // not IDLE
  logic        hand_done;   // pulse with the clear beat
  logic        hand_err;    // pulse with hand_done when no result was seen
  logic        reshuffle;   // pulse with the beat that empties the deck
  logic [5:0]  cards_left;  // undealt cards 0..52
  logic [7:0]  wins;        // saturating win count
  logic [7:0]  losses;      // saturating loss count

  modport master (
    input  start, seed_load, seed, win, lose,
    output out_valid, card, busy, hand_done, hand_err, reshuffle,
           cards_left, wins, losses
  );

  modport slave (
    output start, seed_load, seed, win, lose,
    input  out_valid, card, busy, hand_done, hand_err, reshuffle,
           cards_left, wins, losses
  );
endinterface

`default_nettype wire

// File: rtl/card_dealer.sv
//------------------------------------------------------------------------------
// card_dealer
//   Card-stream source for the hand-scoring block. Keeps a 52-card deck as
//   per-rank counts, draws pseudo-randomly with a 16-bit LFSR, presents each
//   card as a one-cycle beat, reads back win/lose, closes each hand with a
//   clear beat (card 0) and keeps win/loss statistics.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : card_dealer_if.master (control in, beats/statistics out)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module card_dealer #(
  parameter int unsigned MAX_CARDS    = 11,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  card_dealer_if.master bus
);

  localparam int unsigned        BEAT_W      = $clog2(MAX_CARDS + 1);
  localparam logic [BEAT_W-1:0]  C_MAX_BEATS = BEAT_W'(MAX_CARDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAW  = 3'd1,
    S_DEAL  = 3'd2,
    S_WAIT  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t             state_q;
  logic [15:0]        lfsr_q;
  logic [3:0]         rank_q;        // rank currently under test in DRAW
  logic [2:0]         count_q [13];  // remaining cards per rank (index = rank-1)
  logic [5:0]         cards_left_q;
  logic [7:0]         wins_q;
  logic [7:0]         losses_q;
  logic [BEAT_W-1:0]  beats_q;
  logic               out_valid_q;
  logic [3:0]         card_q;
  logic               busy_q;
  logic               hand_done_q;
  logic               hand_err_q;
  logic               reshuffle_q;

  logic [15:0]        lfsr_d;
  logic [3:0]         rank_scan_d;
  logic [3:0]         rank_idx;
  logic               rank_hit;

  // Fold a 4-bit LFSR slice onto ranks 1..13.
  function automatic logic [3:0] rank_of(input logic [3:0] c);
    return ((c >= 4'd13) ? (c - 4'd13) : c) + 4'd1;
  endfunction

  assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign rank_scan_d = (rank_q == 4'd13) ? 4'd1 : rank_q + 4'd1;
  assign rank_idx    = rank_q - 4'd1;
  assign rank_hit    = (count_q[rank_idx] != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED_DEFAULT;
      rank_q       <= 4'd1;
      cards_left_q <= 6'd52;
      wins_q       <= 8'd0;
      losses_q     <= 8'd0;
      beats_q      <= '0;
      out_valid_q  <= 1'b0;
      card_q       <= 4'd0;
      busy_q       <= 1'b0;
      hand_done_q  <= 1'b0;
      hand_err_q   <= 1'b0;
      reshuffle_q  <= 1'b0;
      for (int i = 0; i < 13; i++) begin
        count_q[i] <= 3'd4;
      end
    end else begin
      // Beats and pulses last exactly one cycle unless re-armed below.
      out_valid_q <= 1'b0;
      card_q      <= 4'd0;
      hand_done_q <= 1'b0;
      hand_err_q  <= 1'b0;
      reshuffle_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.seed_load) begin
            // A zero seed would lock the LFSR at zero.
            lfsr_q <= (bus.seed == 16'd0) ? SEED_DEFAULT : bus.seed;
          end else if (bus.start) begin
            state_q <= S_DRAW;
            busy_q  <= 1'b1;
            beats_q <= '0;
            rank_q  <= rank_of(lfsr_q[3:0]);
          end
        end

        S_DRAW: begin
          if (rank_hit) begin
            count_q[rank_idx] <= count_q[rank_idx] - 3'd1;
            cards_left_q      <= cards_left_q - 6'd1;
            lfsr_q            <= lfsr_d;
            card_q            <= rank_q;
            out_valid_q       <= 1'b1;
            beats_q           <= beats_q + BEAT_W'(1);
            // Flag now so the pulse lines up with the beat that empties the deck.
            reshuffle_q       <= (cards_left_q == 6'd1);
            state_q           <= S_DEAL;
          end else begin
            // The deck is never empty here, so the scan ends within 13 cycles.
            rank_q <= rank_scan_d;
          end
        end

        S_DEAL: begin
          if (cards_left_q == 6'd0) begin
            cards_left_q <= 6'd52;
            for (int i = 0; i < 13; i++) begin
              count_q[i] <= 3'd4;
            end
          end
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.win || bus.lose || (beats_q == C_MAX_BEATS)) begin
            // Win takes precedence when both flags are set.
            if (bus.win) begin
              if (wins_q != 8'hFF) wins_q <= wins_q + 8'd1;
            end else if (bus.lose) begin
              if (losses_q != 8'hFF) losses_q <= losses_q + 8'd1;
            end else begin
              hand_err_q <= 1'b1;
            end
            out_valid_q <= 1'b1;
            hand_done_q <= 1'b1;
            state_q     <= S_CLEAR;
          end else begin
            rank_q  <= rank_of(lfsr_q[3:0]);
            state_q <= S_DRAW;
          end
        end

        S_CLEAR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.card       = card_q;
  assign bus.busy       = busy_q;
  assign bus.hand_done  = hand_done_q;
  assign bus.hand_err   = hand_err_q;
  assign bus.reshuffle  = reshuffle_q;
  assign bus.cards_left = cards_left_q;
  assign bus.wins       = wins_q;
  assign bus.losses     = losses_q;

endmodule

`default_nettype wire

// File: doc/card_dealer.md
# card_dealer

Card-stream source for the hand-scoring sequence block. It keeps a 52-card deck as per-rank counts and draws cards pseudo-randomly with a 16-bit LFSR. Each draw is presented as a one-cycle valid beat on the scorer's `in_valid`/`card` inputs. The dealer reads back the scorer's registered `win`/`lose`, closes each hand with a clear beat, and keeps per-game statistics.

## Interface
- `MAX_CARDS`, default 11: beats per hand before a forced close.
- `SEED_DEFAULT`, default 16'hACE1: LFSR value used at reset and in place of a zero seed.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: begin one hand; sampled only in IDLE.
- `seed_load` in 1: load `seed` into the LFSR; sampled only in IDLE, and takes priority over `start`.
- `seed` in 16: LFSR seed.
- `win` in 1: scorer win flag.
- `lose` in 1: scorer lose flag.
- `out_valid` out 1: card beat, drives the scorer's `in_valid`.
- `card` out 4: rank 1..13 (J=11, Q=12, K=13); 0 on clear beats and when idle.
- `busy` out 1: high in any state other than IDLE.
- `hand_done` out 1: one-cycle pulse, coincident with the clear beat.
- `hand_err` out 1: one-cycle pulse with `hand_done` when the hand closed without a result.
- `reshuffle` out 1: one-cycle pulse, coincident with the DEAL beat that empties the deck.
- `cards_left` out 6: undealt cards, 0..52.
- `wins` out 8: hands won, saturating at 255.
- `losses` out 8: hands lost, saturating at 255.

## Operation
- Reset values:
  - state IDLE.
  - `out_valid`, `card`, `hand_done`, `hand_err`, `reshuffle` = 0.
  - all rank counts = 4; `cards_left` = 52.
  - LFSR = `SEED_DEFAULT`.
  - `wins`, `losses`, beat counter = 0.
- LFSR advance: `{lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`. It advances only on a successful draw.
- Seed load: `seed_load` in IDLE loads `seed`, or `SEED_DEFAULT` if `seed` is 0.
- Candidate rank: `c = lfsr[3:0]`; `r = (c>=13 ? c-13 : c) + 1`.
- States:
  - IDLE: outputs quiet. `start` moves to DRAW and clears the beat counter.
  - DRAW: tests one rank per cycle.
    - If count[r] != 0: latch `card = r`, decrement count[r] and `cards_left`, advance the LFSR, go to DEAL.
    - Otherwise: `r = (r==13) ? 1 : r+1`, stay in DRAW.
    - A scan never exceeds 13 cycles, because the deck is never empty in DRAW.
  - DEAL: `out_valid=1` with the latched `card`; beat counter +1.
    - If `cards_left` is now 0: reload all counts to 4, set `cards_left` to 52, pulse `reshuffle`.
    - Go to WAIT.
  - WAIT: `out_valid=0`; sample `win`/`lose`.
    - `win` set: `wins`+1 (saturating), go to CLEAR.
    - Else `lose` set: `losses`+1 (saturating), go to CLEAR.
    - Else beat counter == `MAX_CARDS`: flag error, go to CLEAR.
    - Else: recompute `r` from the current LFSR, go to DRAW.
  - CLEAR: `out_valid=1`, `card=0`, pulse `hand_done`, plus `hand_err` if the error flag is set. Go to IDLE.
    - The clear beat is required: the scorer resets sum/win/lose on the first valid beat after a result and discards that beat's card.
    - The clear beat consumes no deck card.
- `win` and `lose` both high in WAIT counts as a win.
- `start`/`seed_load` outside IDLE are ignored.
- Deck counts and statistics persist across hands; only reset clears them.

## Timing
- All outputs are registered.
- `start` sampled at edge T: DRAW during T+1, first beat (`out_valid`) during T+2 when no scan skip occurs. Each skipped rank adds 1 cycle.
- Beat cadence: DEAL, WAIT, DRAW(≥1 cycle), DEAL… so at least 3 cycles between card beats.
- Scorer result for a beat at cycle N is visible at N+1 (WAIT).
- Clear beat at N+2 after the deciding beat. Back in IDLE at N+3, when a new `start` is accepted.
- Reset mid-hand returns everything to reset values immediately. The scorer, sharing `rst_n`, resets with it.

## Test plan
- Reset, then seed_load `seed`=16'h0001, then start; scorer model never responds:
  - cards 2, 3, 5 on beats 1–3 (LFSR 0001→0002→0004→0008).
  - `hand_err` + `hand_done` with clear beat `card`=0 after beat 11.
- seed_load `seed`=0, then start: LFSR = 16'hACE1; first card 2.
- Real scorer attached, fixed seed:
  - every card beat is followed by WAIT.
  - result at WAIT produces a clear beat at +1 cycle.
  - `wins`/`losses` match a reference scorer model.
  - scorer sum = 0 after each clear beat.
- Deal 52 cards across back-to-back hands:
  - each rank appears exactly 4 times.
  - `reshuffle` pulses on beat 52; `cards_left` returns to 52.
  - DRAW length = 1 + ranks skipped.
- `win` and `lose` both forced high in WAIT: `wins`+1, `losses` unchanged.
- `rst_n` low during DRAW and during WAIT:
  - `out_valid`=0 and `busy`=0 immediately.
  - `cards_left`=52, `wins`=`losses`=0.
